hub75_bcm_driver: RTL and testbench
===================================

# hub75_bcm_driver

Parametrised HUB75 LED-matrix scan driver with per-channel colour depth and a double-buffered framebuffer. A producer (SPI board receiver or game logic) writes RGB pixels into the back buffer and requests a swap. The driver scans the front buffer continuously using binary-code modulation (BCM), driving the matrix RGB0/RGB1, row address, shift clock, latch and blank pins. It replaces the fixed 32x32 one-bit monochrome scanner with arbitrary geometry, grey levels and tear-free frame updates.

## Interface
- COLS, default 32: pixels per matrix row; power of two, ≥ 4.
- ROWS, default 32: matrix rows; even; scan depth SCAN = ROWS/2; A width AW = clog2(SCAN).
- BPP, default 4: bits per colour channel, 1..8.
- BASE_T, default 8: display cycles for bit plane 0; plane b displays BASE_T<<b cycles.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  pixel write strobe.
- wr_row  in  clog2(ROWS)  pixel row.
- wr_col  in  clog2(COLS)  pixel column.
- wr_rgb  in  3*BPP  {R,G,B}, R in the MSBs.
- swap_req  in  1  level request to exchange front and back buffers.
- swap_ack  out  1  one-cycle pulse when the swap commits.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- R0, G0, B0, R1, G1, B1  out  1 each  shift data for the upper half (row r) and lower half (row r+SCAN).
- mclk  out  1  matrix shift clock.
- A  out  AW  row address.
- lch  out  1  latch strobe.
- blank  out  1  output-enable, active high (1 = dark).

## Operation
- Two framebuffers of ROWS×COLS×3×BPP bits; `fsel` selects the front buffer. Writes always target buffer ~fsel as of the write cycle. Reset does not clear contents; reset sets fsel=0.
- Writes with wr_en=1 complete in 1 cycle and are never stalled. Writes are independent of the scan.
- Scan counters: row r (0..SCAN-1) and plane b (0..BPP-1). For each (r, b) the FSM runs SHIFT → LATCH → DISPLAY.
- SHIFT (2*COLS cycles, k = 0..2*COLS-1):
  - On even k, the RGB outputs carry bit b of front-buffer pixels (r, k/2) and (r+SCAN, k/2), with mclk=0.
  - On odd k, mclk=1 and the data is held.
  - blank=1 throughout.
- LATCH (1 cycle): lch=1, blank=1, mclk=0, RGB=0, A←r.
- DISPLAY (BASE_T<<b cycles): blank=0, lch=0, mclk=0, RGB=0, A held.
  - On the last cycle, advance b. If b wraps, b←0 and advance r. If r wraps from SCAN-1 to 0, this is the frame boundary. Then return to SHIFT.
- Frame boundary, in the last DISPLAY cycle of (SCAN-1, BPP-1):
  - frame_done=1.
  - If swap_req=1: toggle fsel and set swap_ack=1 in that same cycle. The next SHIFT reads the new front buffer.
  - A write in the commit cycle lands in the pre-commit back buffer.
  - The producer must not write between raising swap_req and seeing swap_ack, and must drop swap_req the cycle after swap_ack. A swap_req still high at the next boundary swaps again.
- A changes only in LATCH, when blank=1. lch is never high while blank=0.

## Timing
- All outputs are registered.
- Reset values: RGB all 0, mclk 0, lch 0, blank 1, A 0, swap_ack 0, frame_done 0.
- Internal state after reset: r=0, b=0, k=0, state SHIFT.
- First cycle after reset deassertion is SHIFT k=0. The first mclk rise is on cycle index 1.
- Plane length = 2*COLS + 1 + (BASE_T<<b) cycles. Row length = BPP*(2*COLS+1) + BASE_T*(2^BPP − 1). Frame length = SCAN × row length. Defaults give 380 cycles per row and 6080 cycles per frame.
- Read latency must be hidden: data for pixel k/2 is valid on the same cycle as the even k, with no bubbles between pixels or states.
- reset asserted in any state takes effect at the next posedge: all outputs return to reset values, any pending swap is dropped, fsel←0, and framebuffer contents are kept.

## Test plan
- Reset: hold reset 3 cycles, then release. Required: blank=1, lch=0, A=0; mclk goes 0,1,0,1… from release; swap_ack=frame_done=0.
- Single pixel: write (0, 0) = R=0xF and (16, 31) = B=0x5 into buffer 1, assert swap_req.
  - After the boundary, swap_ack pulses once with frame_done.
  - In the row-0 planes, R0=1 at k=0 for every b.
  - B1 at k=62 is 1 for b=0 and b=2, and 0 for b=1 and b=3.
- BCM durations: defaults, count the blank=0 run lengths in one row. Required: 8, 16, 32, 64 cycles. Row period is 380 cycles; frame_done period is 6080 cycles.
- Swap hold-off: keep swap_req high for 2 frames. Required: two swap_ack pulses, each coincident with frame_done. With swap_req low there is no ack and fsel is unchanged.
- Write during commit: write a pixel in the swap_ack cycle. Required: the value appears in the displayed (new front) frame.
- Reset mid-operation: assert reset at SHIFT k=17 of (r=5, b=2). Required: next cycle blank=1, A=0, mclk=0. The scan restarts at r=0, b=0, and pre-reset pixel data is still displayed.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan driver: double-buffered RGB framebuffer shown with binary-code modulation.
// Every output is a register loaded from the next-state decode, so pin timing follows the scan state directly.
module hub75_bcm_driver #(
  parameter int COLS   = 32,
  parameter int ROWS   = 32,
  parameter int BPP    = 4,
  parameter int BASE_T = 8,
  localparam int SCAN  = ROWS / 2,
  localparam int AW    = (SCAN > 1) ? $clog2(SCAN) : 1,
  localparam int RW    = $clog2(ROWS),
  localparam int CW    = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [3*BPP-1:0]  wr_rgb,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              frame_done,
  output logic              R0,
  output logic              G0,
  output logic              B0,
  output logic              R1,
  output logic              G1,
  output logic              B1,
  output logic              mclk,
  output logic [AW-1:0]     A,
  output logic              lch,
  output logic              blank
);

  localparam int KW    = $clog2(2 * COLS);
  localparam int TW    = $clog2((BASE_T << (BPP - 1)) + 1);
  localparam int BW    = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int PW    = 3 * BPP;
  localparam int DEPTH = 2 * ROWS * COLS;
  localparam int MW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t        state, state_n;
  logic [KW-1:0] k, k_n;
  logic [TW-1:0] t, t_n;
  logic [AW-1:0] r, r_n;
  logic [BW-1:0] b, b_n;
  logic          fsel, fsel_n;

  logic [PW-1:0] fb [DEPTH];
  logic [MW-1:0] addr_up, addr_lo, addr_wr;
  logic [PW-1:0] pix_up, pix_lo;

  logic [5:0]    rgb_n;
  logic          mclk_n, lch_n, blank_n, ack_n, done_n;
  logic [AW-1:0] a_n;

  function automatic logic [2:0] plane_bits(input logic [PW-1:0] p, input logic [BW-1:0] bsel);
    logic [BPP-1:0] rc, gc, bc;
    {rc, gc, bc} = p;
    return {rc[bsel], gc[bsel], bc[bsel]};
  endfunction

  // Producer writes always land in the buffer that is not being scanned.
  assign addr_wr = MW'((fsel ? 0 : ROWS * COLS) + int'(wr_row) * COLS + int'(wr_col));

  always_ff @(posedge clk) begin
    if (wr_en) fb[addr_wr] <= wr_rgb;
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    t_n     = t;
    r_n     = r;
    b_n     = b;
    done_n  = 1'b0;
    ack_n   = 1'b0;
    // A committed swap takes effect at the end of the ack cycle.
    fsel_n  = swap_ack ? ~fsel : fsel;

    case (state)
      S_SHIFT: begin
        if (k == KW'(2 * COLS - 1)) state_n = S_LATCH;
        else k_n = k + KW'(1);
      end
      S_LATCH: begin
        state_n = S_DISPLAY;
        t_n     = TW'((BASE_T << b) - 1);
      end
      S_DISPLAY: begin
        if (t == '0) begin
          state_n = S_SHIFT;
          k_n     = '0;
          if (b == BW'(BPP - 1)) begin
            b_n = '0;
            r_n = (r == AW'(SCAN - 1)) ? '0 : r + AW'(1);
          end else begin
            b_n = b + BW'(1);
          end
        end else begin
          t_n = t - TW'(1);
        end
      end
      default: state_n = S_SHIFT;
    endcase

    if (state_n == S_DISPLAY && t_n == '0 && r_n == AW'(SCAN - 1) && b_n == BW'(BPP - 1)) begin
      done_n = 1'b1;
      ack_n  = swap_req;
    end

    addr_up = MW'((fsel_n ? ROWS * COLS : 0) + int'(r_n) * COLS + int'(k_n >> 1));
    addr_lo = MW'((fsel_n ? ROWS * COLS : 0) + (int'(r_n) + SCAN) * COLS + int'(k_n >> 1));
    pix_up  = fb[addr_up];
    pix_lo  = fb[addr_lo];

    rgb_n   = '0;
    mclk_n  = 1'b0;
    lch_n   = 1'b0;
    blank_n = 1'b1;
    a_n     = A;
    case (state_n)
      S_SHIFT: begin
        mclk_n = k_n[0];
        if (k_n[0]) rgb_n = {R0, G0, B0, R1, G1, B1};
        else rgb_n = {plane_bits(pix_up, b_n), plane_bits(pix_lo, b_n)};
      end
      S_LATCH: begin
        lch_n = 1'b1;
        a_n   = r_n;
      end
      S_DISPLAY: blank_n = 1'b0;
      default: ;
    endcase
  end

  // Reset forces RGB low, so the very first pixel after reset is shown dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_SHIFT;
      k          <= '0;
      t          <= '0;
      r          <= '0;
      b          <= '0;
      fsel       <= 1'b0;
      {R0, G0, B0, R1, G1, B1} <= '0;
      mclk       <= 1'b0;
      lch        <= 1'b0;
      blank      <= 1'b1;
      A          <= '0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      t          <= t_n;
      r          <= r_n;
      b          <= b_n;
      fsel       <= fsel_n;
      {R0, G0, B0, R1, G1, B1} <= rgb_n;
      mclk       <= mclk_n;
      lch        <= lch_n;
      blank      <= blank_n;
      A          <= a_n;
      swap_ack   <= ack_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: every cycle is compared against a positional model of the scan
// (frame offset -> row/plane/phase by arithmetic) plus directed checks on swap, BCM and reset behaviour.
module tb_hub75_bcm_driver;

  localparam int COLS   = 32;
  localparam int ROWS   = 32;
  localparam int BPP    = 4;
  localparam int BASE_T = 8;
  localparam int SCAN   = ROWS / 2;
  localparam int ROWLEN = BPP * (2 * COLS + 1) + BASE_T * ((1 << BPP) - 1);
  localparam int FRAME  = SCAN * ROWLEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_row = '0;
  logic [4:0]  wr_col = '0;
  logic [11:0] wr_rgb = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack, frame_done, R0, G0, B0, R1, G1, B1, mclk, lch, blank;
  logic [3:0]  A;

  always #5 clk = ~clk;

  hub75_bcm_driver #(.COLS(COLS), .ROWS(ROWS), .BPP(BPP), .BASE_T(BASE_T)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_rgb(wr_rgb), .swap_req(swap_req), .swap_ack(swap_ack), .frame_done(frame_done),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .mclk(mclk), .A(A), .lch(lch), .blank(blank)
  );

  int tests = 0;
  int fails = 0;

  logic [11:0] fbm [2][ROWS][COLS];
  bit          filled [2];
  int          pos, mfsel, ma;
  bit          first, prev_ack;
  int          cyc = 0;
  int          fd_last = -1;
  int          fd_period = 0;
  int          run_len = 0;
  int          runs[$];
  int          lch_cyc[$];
  int          ack_count = 0;

  function automatic int plane_start(input int pb);
    int s = 0;
    for (int j = 0; j < pb; j++) s += 2 * COLS + 1 + (BASE_T << j);
    return s;
  endfunction

  // Frame offset -> row, plane, phase (0 shift, 1 latch, 2 display), shift index.
  task automatic decode(input int p, output int dr, output int db, output int ph, output int dk);
    int o;
    dr = p / ROWLEN;
    o  = p % ROWLEN;
    db = BPP - 1;
    for (int j = 0; j < BPP; j++) begin
      if (o < 2 * COLS + 1 + (BASE_T << j)) begin
        db = j;
        break;
      end
      o -= 2 * COLS + 1 + (BASE_T << j);
    end
    if (o < 2 * COLS) begin ph = 0; dk = o; end
    else if (o == 2 * COLS) begin ph = 1; dk = 0; end
    else begin ph = 2; dk = o - 2 * COLS - 1; end
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    bit rs, we, sr;
    logic [4:0] wrr, wcc;
    logic [11:0] wv, up, lo;
    logic [5:0] rgb;
    logic [14:0] expv, obsv;
    int dr, db, ph, dk;
    bit fd, ack, emclk, elch, eblank;
    rs = reset; we = wr_en; sr = swap_req; wrr = wr_row; wcc = wr_col; wv = wr_rgb;
    @(posedge clk);
    #1;
    cyc++;
    rgb = '0; emclk = 1'b0; elch = 1'b0; eblank = 1'b1; fd = 1'b0; ack = 1'b0;
    if (rs) begin
      pos = 0; mfsel = 0; ma = 0; first = 1'b1; prev_ack = 1'b0;
    end else begin
      if (we) fbm[1 - mfsel][wrr][wcc] = wv;
      if (prev_ack) mfsel = 1 - mfsel;
      pos++;
      if (pos == FRAME) begin pos = 0; first = 1'b0; end
      decode(pos, dr, db, ph, dk);
      if (ph == 0) begin
        emclk = dk[0];
        if (!(first && pos < 2)) begin
          up  = fbm[mfsel][dr][dk / 2];
          lo  = fbm[mfsel][dr + SCAN][dk / 2];
          rgb = {1'(up >> (8 + db)), 1'(up >> (4 + db)), 1'(up >> db),
                 1'(lo >> (8 + db)), 1'(lo >> (4 + db)), 1'(lo >> db)};
        end
      end else if (ph == 1) begin
        elch = 1'b1;
        ma   = dr;
      end else begin
        eblank = 1'b0;
      end
      fd  = (pos == FRAME - 1);
      ack = fd && sr;
      prev_ack = ack;
    end
    expv = {rgb, emclk, 4'(ma), elch, eblank, ack, fd};
    obsv = {R0, G0, B0, R1, G1, B1, mclk, A, lch, blank, swap_ack, frame_done};
    if (!filled[mfsel]) begin
      expv[14:9] = '0;
      obsv[14:9] = '0;
    end
    tests++;
    assert (obsv === expv) else begin
      fails++;
      $error("FAIL scan cyc=%0d pos=%0d got=%h exp=%h", cyc, pos, obsv, expv);
    end
    if (!blank) run_len++;
    else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
    if (lch) lch_cyc.push_back(cyc);
    if (frame_done) begin
      if (fd_last >= 0) fd_period = cyc - fd_last;
      fd_last = cyc;
    end
    if (swap_ack) ack_count++;
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < FRAME + 2 && pos != target; i++) tick();
    check("reach_pos", pos, target);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < FRAME + 10 && !swap_ack; i++) tick();
    check("swap_ack_seen", int'(swap_ack), 1);
    check("ack_with_fd", int'(frame_done), 1);
  endtask

  task automatic fill_buffer(input int which);
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int cc = 0; cc < COLS; cc++) begin
        wr_en  = 1'b1;
        wr_row = 5'(rr);
        wr_col = 5'(cc);
        wr_rgb = 12'($urandom);
        if (which == 1 && rr == 0 && cc == 0) wr_rgb = 12'hF00;
        if (which == 1 && rr == 16 && cc == 31) wr_rgb = 12'h005;
        tick();
      end
    end
    wr_en = 1'b0;
    filled[which] = 1'b1;
  endtask

  initial begin
    logic [11:0] cv, px_up, px_lo;
    filled[0] = 1'b0;
    filled[1] = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_blank", int'(blank), 1);
    check("rst_lch", int'(lch), 0);
    check("rst_A", int'(A), 0);
    check("rst_mclk0", int'(mclk), 0);
    check("rst_ack", int'(swap_ack), 0);
    check("rst_fd", int'(frame_done), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("rst_mclk_toggle", int'(mclk), i % 2);
    end

    // Front is buffer 0 after reset, so these writes go to buffer 1.
    fill_buffer(1);
    swap_req = 1'b1;
    ack_count = 0;
    wait_ack();
    swap_req = 1'b0;
    tick();
    check("single_ack", ack_count, 1);

    for (int pb = 0; pb < BPP; pb++) begin
      run_until(plane_start(pb));
      check("px00_R0", int'(R0), 1);
      run_until(plane_start(pb) + 62);
      check("px16_31_B1", int'(B1), (5 >> pb) & 1);
    end

    run_until(ROWLEN);
    runs.delete();
    lch_cyc.delete();
    run_len = 0;
    run_until(2 * ROWLEN + 2 * COLS);
    check("bcm_runs", runs.size(), 4);
    for (int pb = 0; pb < BPP && pb < runs.size(); pb++) check("bcm_len", runs[pb], BASE_T << pb);
    check("lch_count", lch_cyc.size(), 5);
    if (lch_cyc.size() == 5) check("row_period", lch_cyc[4] - lch_cyc[0], ROWLEN);

    fill_buffer(0);
    swap_req = 1'b1;
    ack_count = 0;
    for (int i = 0; i < 2 * FRAME + 20 && ack_count < 2; i++) begin
      tick();
      if (swap_ack) check("hold_ack_fd", int'(frame_done), 1);
    end
    check("hold_acks", ack_count, 2);
    check("fd_period", fd_period, FRAME);
    swap_req = 1'b0;

    ack_count = 0;
    repeat (FRAME) tick();
    check("noswap_fd", int'(frame_done), 1);
    check("noswap_acks", ack_count, 0);

    swap_req = 1'b1;
    wait_ack();
    cv = 12'($urandom) | 12'h800;
    wr_en = 1'b1; wr_row = 5'd3; wr_col = 5'd7; wr_rgb = cv;
    swap_req = 1'b0;
    tick();
    wr_en = 1'b0;
    for (int pb = 0; pb < BPP; pb++) begin
      run_until(3 * ROWLEN + plane_start(pb) + 14);
      check("commit_wr_rgb", int'({R0, G0, B0}),
            int'({1'(cv >> (8 + pb)), 1'(cv >> (4 + pb)), 1'(cv >> pb)}));
    end

    run_until(5 * ROWLEN + plane_start(2) + 17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_blank", int'(blank), 1);
    check("midrst_A", int'(A), 0);
    check("midrst_mclk", int'(mclk), 0);
    run_until(4);
    px_up = fbm[0][0][2];
    px_lo = fbm[0][16][2];
    check("midrst_data", int'({R0, G0, B0, R1, G1, B1}),
          int'({px_up[8], px_up[4], px_up[0], px_lo[8], px_lo[4], px_lo[0]}));
    repeat (ROWLEN) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
